// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store front end.
// Provides the access-size encodings, the FSM state enum, the captured request
// payload and the default memory word-line index width.
package mem_access_unit_pkg;

  localparam int unsigned LINE_BITS_DEF = 12;
  localparam int unsigned DATA_W        = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Request fields kept after the handshake (the line index is held separately
  // because its width follows the LINE_BITS parameter).
  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              uns;
    logic [1:0]        lane;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering between a memory word and the core.
// Ports:
//   word         - word read from memory
//   lane         - byte offset within the word (addr[1:0])
//   size         - access size encoding
//   is_unsigned  - zero-extend loads when 1, sign-extend when 0
//   wdata        - right-aligned store data
//   load_data_c  - extracted and extended load result
//   merge_data_c - word with the store data merged into the addressed lane(s)
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merge_data_c
);

  logic [4:0]        shamt;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [DATA_W-1:0] mask;

  // Little-endian: lane 0 is bits 7:0, so a lane is a shift of 8*lane bits.
  assign shamt = {lane, 3'b000};
  assign sel_b = 8'(word >> shamt);
  assign sel_h = 16'(word >> shamt);

  always_comb begin
    load_data_c  = word;
    mask         = '1;
    case (size)
      SZ_BYTE: begin
        load_data_c = is_unsigned ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
        mask        = 32'h0000_00FF;
      end
      SZ_HALF: begin
        load_data_c = is_unsigned ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
        mask        = 32'h0000_FFFF;
      end
      default: begin
        load_data_c = word;
        mask        = '1;
      end
    endcase
    merge_data_c = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the unified word memory data port.
// Turns byte-addressed byte/half/word requests into word-line accesses, does a
// read-modify-write for sub-word stores, flags misaligned/out-of-range/illegal
// accesses and answers over a valid/ready response channel.
// Ports:
//   clk, reset_n                  - clock, synchronous active-low reset
//   req_valid/req_ready           - request handshake
//   req_write, req_addr, req_size,
//   req_unsigned, req_wdata       - request payload
//   resp_valid/resp_ready         - response handshake
//   resp_rdata, resp_error        - response payload
//   mem_line, mem_write,
//   mem_write_data, mem_data      - memory data port (mem_data is combinational)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned       LINE_BITS = LINE_BITS_DEF,
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 resp_error,
  output logic [LINE_BITS-1:0] mem_line,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    mem_write_data,
  input  logic [DATA_W-1:0]    mem_data
);

  state_e                state, state_nxt;
  req_t                  req_q;
  logic [LINE_BITS-1:0]  line_q;
  logic [DATA_W-1:0]     merge_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic                  accept_c;
  logic                  req_err_c;
  logic [DATA_W-1:0]     load_c;
  logic [DATA_W-1:0]     merge_c;

  assign accept_c   = req_valid && (state == ST_IDLE);
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;

  // Reject illegal size, misalignment and anything above the memory span.
  always_comb begin
    req_err_c = 1'b0;
    if (req_size == SZ_ILL)                             req_err_c = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])           req_err_c = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 0))  req_err_c = 1'b1;
    if ((req_addr >> (LINE_BITS + 2)) != '0)            req_err_c = 1'b1;
  end

  mem_access_unit_lane_align u_lane_align (
    .word         (mem_data),
    .lane         (req_q.lane),
    .size         (req_q.size),
    .is_unsigned  (req_q.uns),
    .wdata        (req_q.wdata),
    .load_data_c  (load_c),
    .merge_data_c (merge_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = req_err_c ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nxt = (req_q.write && (req_q.size != SZ_WORD)) ? ST_WRITE : ST_RESP;
      ST_WRITE:  state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Port outputs decoded from state; writes are also gated by reset_n so a
  // reset landing on a write cycle never corrupts memory.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_line       = '0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_ACCESS: begin
        mem_line = line_q;
        if (req_q.write && (req_q.size == SZ_WORD)) begin
          mem_write      = reset_n;
          mem_write_data = reset_n ? req_q.wdata : '0;
        end
      end
      ST_WRITE: begin
        mem_line       = line_q;
        mem_write      = reset_n;
        mem_write_data = reset_n ? merge_q : '0;
      end
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Captured request, merged store word and response registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q   <= '0;
      line_q  <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        req_q   <= '{write: req_write, size: req_size, uns: req_unsigned,
                     lane: req_addr[1:0], wdata: req_wdata};
        line_q  <= req_addr[LINE_BITS+1:2];
        err_q   <= req_err_c;
        rdata_q <= req_err_c ? ERR_RDATA : '0;
      end
      if (state == ST_ACCESS) begin
        if (!req_q.write) rdata_q <= load_c;
        merge_q <= merge_c;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the unified word memory's data port.
- Converts core byte-addressed load/store requests (byte, halfword, word; signed or unsigned loads) into word-line accesses.
- Performs a two-cycle read-modify-write for sub-word stores.
- Detects misaligned and out-of-range accesses, and returns results over a valid/ready response handshake.

Parameters:
- LINE_BITS, 12, width of the memory word-line index; addressable space is 4*2^LINE_BITS bytes.
- ERR_RDATA, 32'h0000_0000, resp_rdata value returned on an error response.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal (error)
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response available
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_error  out  1  misaligned, out-of-range or illegal size
- mem_line  out  LINE_BITS  word index to memory data port
- mem_write  out  1  memory write strobe
- mem_write_data  out  32  full word to write
- mem_data  in  32  combinational read word from memory at mem_line

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP.
- Reset (reset_n=0 at a clock edge): state=IDLE; captured registers cleared.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_line=0, mem_write=0, mem_write_data=0.
- mem_write is additionally gated by reset_n, so no write occurs in any cycle where reset_n=0, including reset mid-WRITE.
- req_ready=1 only in IDLE. A handshake (req_valid & req_ready) at edge T captures addr, size, write, unsigned and wdata.
- Error check at capture:
  - size==3;
  - half with addr[0]!=0;
  - word with addr[1:0]!=0;
  - addr[31:LINE_BITS+2]!=0.
- On error: go to RESP with resp_error=1 and resp_rdata=ERR_RDATA; no memory access.
- Otherwise go to ACCESS.
- mem_line = captured addr[LINE_BITS+1:2] in ACCESS and WRITE; 0 in IDLE and RESP.
- ACCESS, load:
  - select the byte/half of mem_data by addr[1:0] (little-endian, byte 0 = bits 7:0);
  - extend per req_unsigned, register into resp_rdata;
  - go to RESP.
- ACCESS, word store: mem_write=1, mem_write_data=wdata; write lands at the end of this cycle; go to RESP.
- ACCESS, sub-word store:
  - merge wdata[7:0] or wdata[15:0] into mem_data at lane addr[1:0]; register the merged word; mem_write=0;
  - go to WRITE.
- WRITE: mem_write=1, mem_write_data=registered merged word; go to RESP.
- RESP:
  - resp_valid=1; resp_rdata/resp_error held stable until resp_ready;
  - resp_valid & resp_ready -> IDLE; the next request can be accepted one cycle later.
  - Stores return resp_rdata=0, resp_error=0.
- Latency from request edge T to first resp_valid cycle:
  - load: T+2; word store: T+2; sub-word store: T+3; error: T+1.
- Back-to-back: accepted requests are never dropped; a stalled resp_ready holds the unit in RESP with req_ready=0.
- mem_write_data=0 whenever mem_write=0.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - state enum;
  - LINE_BITS default.
- One natural combinational sub-module, lane_align: load extraction/extension and store merge, keyed on addr[1:0], size and unsigned.

Test Plan:
- Word load: memory line 5 = 32'h8081_8283; load word at addr 0x14 -> resp_valid at T+2, rdata=32'h8081_8283, error=0.
- Byte loads, same word:
  - addr 0x17 signed -> 32'hFFFF_FF80;
  - addr 0x17 unsigned -> 32'h0000_0080;
  - half at addr 0x14 signed -> 32'hFFFF_8283.
- Sub-word store: line 5 = 32'h1122_3344; store byte 8'hAB at addr 0x15 -> mem_write only in WRITE cycle (T+2) with data 32'h1122_AB44; resp at T+3; a following word load returns 32'h1122_AB44.
- Errors, each -> resp at T+1 with error=1 and mem_write never asserted:
  - half store at addr 0x13;
  - word load at 0x16;
  - load at addr 0x0001_0000;
  - size=3.
- Handshake: hold resp_ready=0 for 3 cycles -> resp_valid, rdata and error stable, req_ready=0; second request waits and completes correctly.
- Reset mid-operation: assert reset_n=0 while in WRITE -> no memory update, all outputs at reset values after the edge, req_ready=1.
